// File: rtl/acc_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg
// Definitions shared by the accumulator datapath and its operand feeder.
//   ACC_DATA_W : default operand width, equal to the accumulator input width
//   operand_t  : one accumulator operand
//   ALU_OP_ADD : opcode the accumulator uses to add an incoming operand
// ----------------------------------------------------------------------------
package acc_pkg;

    localparam int ACC_DATA_W = 4;

    typedef logic [ACC_DATA_W-1:0] operand_t;

    localparam logic [2:0] ALU_OP_ADD = 3'b100;

endpackage

// File: rtl/acc_feeder_if.sv
// ----------------------------------------------------------------------------
// acc_feeder_if
// Groups the operand-entry controls and the accumulator-side outputs of
// acc_feeder.
//   sw, btn_raw, drain                        : driven toward the feeder
//   acc_in, acc_en, count, full, empty, drop  : produced by the feeder
// Modports:
//   slave  : the feeder itself
//   master : whoever drives the switches/button and observes the outputs
// ----------------------------------------------------------------------------
interface acc_feeder_if
    import acc_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int DEPTH  = 4
);

    logic [DATA_W-1:0]        sw;
    logic                     btn_raw;
    logic                     drain;
    logic [DATA_W-1:0]        acc_in;
    logic                     acc_en;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic                     drop;

    modport slave (
        input  sw, btn_raw, drain,
        output acc_in, acc_en, count, full, empty, drop
    );

    modport master (
        output sw, btn_raw, drain,
        input  acc_in, acc_en, count, full, empty, drop
    );

endinterface

// File: rtl/acc_feeder_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push-button into the clk domain, debounces it and emits
// a single-cycle pulse for every clean press (release produces nothing).
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous reset, active-high despite its name
//   btn_raw : raw, bouncing button level
//   press   : registered one-cycle pulse on each debounced 0->1 transition
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic             s1;
    logic             s2;
    logic             db_state;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    // The level has disagreed with db_state long enough; this edge accepts it.
    assign settle = (s2 != db_state) && (cnt == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            db_state <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            // Only the rising transition of the debounced level is a press.
            press <= settle && !db_state;
            if (s2 == db_state) begin
                cnt <= '0;
            end else if (settle) begin
                cnt      <= '0;
                db_state <= ~db_state;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_feeder.sv
// ----------------------------------------------------------------------------
// acc_feeder
// Operand-entry stage in front of the 4-bit accumulator. Each clean button
// press captures the registered switch value into a small FIFO; while drain
// is high the FIFO is emptied one operand per cycle onto acc_in/acc_en.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active-high despite its name
//   bus   : acc_feeder_if.slave
//           sw/btn_raw/drain in; acc_in, acc_en, count, full, empty, drop out
// ----------------------------------------------------------------------------
module acc_feeder
    import acc_pkg::*;
#(
    parameter int DATA_W    = ACC_DATA_W,
    parameter int DEPTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    acc_feeder_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] sw_q;
    logic              push_req;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              do_pop;
    logic              do_push;
    logic [DATA_W-1:0] acc_in_q;
    logic              acc_en_q;
    logic              drop_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_raw),
        .press   (push_req)
    );

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted. A push into an empty FIFO cannot pop the same edge.
    assign do_pop  = bus.drain && !empty;
    assign do_push = push_req && (!full || do_pop);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sw_q     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            acc_in_q <= '0;
            acc_en_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            sw_q     <= bus.sw;
            acc_en_q <= do_pop;
            drop_q   <= push_req && !do_push;
            if (do_pop) begin
                acc_in_q <= mem[rptr];
                rptr     <= rptr + 1'b1;
            end
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= sw_q;
        end
    end

    assign bus.acc_in = acc_in_q;
    assign bus.acc_en = acc_en_q;
    assign bus.drop   = drop_q;
    assign bus.count  = count;
    assign bus.full   = full;
    assign bus.empty  = empty;

endmodule

// File: tb/tb_acc_feeder.sv
// ----------------------------------------------------------------------------
// tb_acc_feeder
// Self-checking bench for acc_feeder with DB_CYCLES=4, DEPTH=4. Operands are
// pushed onto an expected queue when a press is driven and popped whenever
// acc_en is seen; a small downstream accumulator sums what is delivered.
// ----------------------------------------------------------------------------
module tb_acc_feeder;
    import acc_pkg::*;

    localparam int DATA_W    = 4;
    localparam int DEPTH     = 4;
    localparam int DB_CYCLES = 4;

    typedef struct {
        logic [DATA_W-1:0] sw;
        int                exp_count;
        logic              exp_full;
        int                exp_drops;
    } ovf_vec_t;

    logic clk;
    logic rst_n;

    acc_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    acc_feeder #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                total = 0;
    int                bad   = 0;
    logic [DATA_W-1:0] exp_q [$];
    int                en_cnt   = 0;
    int                drop_cnt = 0;
    int                run      = 0;
    int                max_run  = 0;
    operand_t          acc_sum  = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock edge and observe the outputs 2 time units later.
    task automatic step();
        logic [DATA_W-1:0] e;
        @(posedge clk);
        #2;
        if (bus.acc_en === 1'b1) begin
            en_cnt++;
            run++;
            if (run > max_run) max_run = run;
            acc_sum = acc_sum + bus.acc_in;
            if (exp_q.size() == 0) begin
                check_output("unexpected_acc_en", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output("acc_in", {28'd0, bus.acc_in}, {28'd0, e});
            end
        end else begin
            run = 0;
        end
        if (bus.drop === 1'b1) drop_cnt++;
    endtask

    task automatic apply_stimulus(input logic [DATA_W-1:0] v, input bit accept);
        bus.sw = v;
        if (accept) exp_q.push_back(v);
        bus.btn_raw = 1'b1;
        repeat (8) step();
        bus.btn_raw = 1'b0;
        repeat (8) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_acc_en"}, {31'd0, bus.acc_en}, 0);
        check_output({tag, "_acc_in"}, {28'd0, bus.acc_in}, 0);
        check_output({tag, "_count"},  {29'd0, bus.count}, 0);
        check_output({tag, "_empty"},  {31'd0, bus.empty}, 1);
        check_output({tag, "_full"},   {31'd0, bus.full}, 0);
        check_output({tag, "_drop"},   {31'd0, bus.drop}, 0);
    endtask

    initial begin
        ovf_vec_t vecs [5];
        int       mcount;
        int       first_en;
        int       en_before;

        vecs[0] = '{sw: 4'd1, exp_count: 1, exp_full: 1'b0, exp_drops: 0};
        vecs[1] = '{sw: 4'd2, exp_count: 2, exp_full: 1'b0, exp_drops: 0};
        vecs[2] = '{sw: 4'd3, exp_count: 3, exp_full: 1'b0, exp_drops: 0};
        vecs[3] = '{sw: 4'd4, exp_count: 4, exp_full: 1'b1, exp_drops: 0};
        vecs[4] = '{sw: 4'd5, exp_count: 4, exp_full: 1'b1, exp_drops: 1};

        rst_n       = 1'b1;
        bus.sw      = '0;
        bus.btn_raw = 1'b0;
        bus.drain   = 1'b0;

        // Power-on reset state.
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) step();

        // Bouncing press 1,0,1 then steady: one push, landing on edge 6.
        $display("[TB] bounce sequence");
        bus.sw = 4'd6;
        exp_q.push_back(4'd6);
        bus.btn_raw = 1'b1;
        step();
        bus.btn_raw = 1'b0;
        step();
        bus.btn_raw = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k == 5) check_output("bounce_count_edge5", {29'd0, bus.count}, 0);
            if (k == 6) check_output("bounce_count_edge6", {29'd0, bus.count}, 1);
        end
        repeat (10) step();
        bus.btn_raw = 1'b0;
        repeat (10) step();
        check_output("bounce_single_push", {29'd0, bus.count}, 1);
        bus.drain = 1'b1;
        repeat (3) step();
        bus.drain = 1'b0;
        check_output("bounce_drained_empty", {31'd0, bus.empty}, 1);
        check_output("bounce_sb_left", exp_q.size(), 0);

        // Glitch shorter than DB_CYCLES is rejected.
        $display("[TB] glitch");
        bus.sw = 4'd8;
        bus.btn_raw = 1'b1;
        repeat (3) step();
        bus.btn_raw = 1'b0;
        repeat (12) step();
        check_output("glitch_count", {29'd0, bus.count}, 0);

        // Press into an empty FIFO while draining: acc_en one edge after write.
        $display("[TB] empty push with drain");
        bus.drain = 1'b1;
        bus.sw = 4'd7;
        exp_q.push_back(4'd7);
        bus.btn_raw = 1'b1;
        first_en = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.acc_en === 1'b1 && first_en < 0) first_en = k;
        end
        check_output("empty_push_en_edge", first_en, 7);
        bus.btn_raw = 1'b0;
        repeat (8) step();
        bus.drain = 1'b0;
        check_output("empty_push_sb_left", exp_q.size(), 0);

        // Ordering and downstream accumulation: 3+5+9 = 17 -> 4'h1.
        $display("[TB] order");
        apply_stimulus(4'd3, 1'b1);
        apply_stimulus(4'd5, 1'b1);
        apply_stimulus(4'd9, 1'b1);
        check_output("order_count", {29'd0, bus.count}, 3);
        acc_sum = '0;
        max_run = 0;
        bus.drain = 1'b1;
        repeat (6) step();
        bus.drain = 1'b0;
        check_output("order_back_to_back", max_run, 3);
        check_output("order_acc_sum", {28'd0, acc_sum}, 32'h1);
        check_output("order_empty", {31'd0, bus.empty}, 1);
        check_output("order_sb_left", exp_q.size(), 0);

        // Overflow table: fifth press is dropped.
        $display("[TB] overflow table");
        mcount = 0;
        for (int i = 0; i < 5; i++) begin
            drop_cnt = 0;
            apply_stimulus(vecs[i].sw, mcount < DEPTH);
            if (mcount < DEPTH) mcount++;
            check_output($sformatf("ovf%0d_count", i), {29'd0, bus.count}, vecs[i].exp_count);
            check_output($sformatf("ovf%0d_full", i), {31'd0, bus.full}, {31'd0, vecs[i].exp_full});
            check_output($sformatf("ovf%0d_drop", i), drop_cnt, vecs[i].exp_drops);
        end
        bus.drain = 1'b1;
        repeat (6) step();
        bus.drain = 1'b0;
        check_output("ovf_sb_left", exp_q.size(), 0);
        check_output("ovf_empty", {31'd0, bus.empty}, 1);

        // Full FIFO: push lands on the same edge as a pop -> accepted, no drop.
        $display("[TB] simultaneous push/pop");
        for (int i = 0; i < 4; i++) apply_stimulus(4'(10 + i), 1'b1);
        check_output("simul_full_before", {31'd0, bus.full}, 1);
        drop_cnt = 0;
        bus.sw = 4'd14;
        exp_q.push_back(4'd14);
        bus.btn_raw = 1'b1;
        repeat (6) step();
        bus.drain = 1'b1;
        step();
        bus.drain = 1'b0;
        check_output("simul_count", {29'd0, bus.count}, 4);
        bus.btn_raw = 1'b0;
        repeat (8) step();
        check_output("simul_drop", drop_cnt, 0);
        bus.drain = 1'b1;
        repeat (6) step();
        bus.drain = 1'b0;
        check_output("simul_sb_left", exp_q.size(), 0);

        // Reset in the middle of draining discards everything.
        $display("[TB] reset mid-traffic");
        apply_stimulus(4'd1, 1'b1);
        apply_stimulus(4'd2, 1'b1);
        apply_stimulus(4'd3, 1'b1);
        bus.drain = 1'b1;
        step();
        #2;
        rst_n = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        en_before = en_cnt;
        repeat (10) step();
        check_output("post_reset_no_en", en_cnt - en_before, 0);
        bus.drain = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_feeder.md
Name: acc_feeder

Overview:
- Operand-entry stage directly upstream of the 4-bit accumulator.
- Debounces a raw push-button and, on each clean press, captures the 4-bit switch value into a small FIFO.
- Drains the FIFO one operand per cycle as an `acc_in`/`acc_en` pair that drives the accumulator's data and enable inputs.
- Buffering lets several operands be keyed in before accumulation is released with `drain`.

Parameters:
- DATA_W, 4: operand width; matches the accumulator input.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DB_CYCLES, 16: consecutive stable cycles needed to accept a button level change; at least 2. Benches use 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset: asynchronous, active-high (despite the name). Clock is clk.
- sw  input  DATA_W  operand switches, quasi-static.
- btn_raw  input  1  raw, bouncing push-button.
- drain  input  1  level; while 1, one FIFO entry may be popped per cycle.
- acc_in  output  DATA_W  operand to the accumulator; registered.
- acc_en  output  1  one-cycle strobe per popped operand; registered.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop  output  1  one-cycle pulse when a press is lost because the FIFO is full; registered.

Behaviour:
- Reset (async, rst_n=1):
  - sync flops, debounce counter, db_state, FIFO pointers and count all cleared.
  - acc_in=0, acc_en=0, drop=0, full=0, empty=1.
  - Asserting reset mid-operation discards FIFO contents and any debounce in progress.
  - First activity is possible on the first rising clk after rst_n falls.
- Synchronizer: btn_raw passes through 2 flops (s1 then s2). The sw input is registered once (sw_q).
- Debounce:
  - When s2 != db_state, the counter increments; otherwise it clears.
  - At the edge where the counter would reach DB_CYCLES, db_state toggles and the counter clears.
  - Any bounce back to db_state restarts the count.
- Press: db_state 0->1 generates push_req, registered, high for exactly 1 cycle. Release (1->0) generates nothing.
- Latency: btn_raw rises and stays stable before edge 0. Then:
  - db_state=1 after edge DB_CYCLES+1.
  - The FIFO write occurs at edge DB_CYCLES+2, capturing sw_q as it stands at that edge.
- Pop:
  - Occurs at an edge when drain=1 and count>0, evaluated on pre-edge state.
  - After that edge, acc_in = head entry and acc_en=1.
  - Otherwise acc_en=0 and acc_in holds its last value.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - With empty and push, no pop happens that cycle; the entry pops on the following edge if drain is still 1.
  - With full, push and pop together, the push is accepted and drop=0.
- Full without pop: the push is discarded, FIFO is unchanged, and drop=1 for 1 cycle.
- Pointers: wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- full and empty are combinational from count.
- Steady drain: back-to-back pops give consecutive acc_en cycles. This is legal; the accumulator adds each operand.

Decomposition:
- Shared package `acc_pkg`:
  - DATA_W default and operand type (logic [DATA_W-1:0]).
  - ALU opcode constant for ADD (3'b100) used by the accumulator.
- Sub-module `btn_debounce` (params DB_CYCLES):
  - Contains the 2-flop synchronizer, counter and db_state.
  - Outputs a 1-cycle `press` pulse.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset: hold rst_n=1 mid-traffic with 3 entries queued -> immediately acc_en=0, acc_in=0, count=0, empty=1, drop=0. After release, drain=1 produces no acc_en.
- Debounce (DB_CYCLES=4):
  - btn_raw toggles 1,0,1 at 1-cycle spacing, then holds 1 -> exactly one push.
  - The push lands at edge 6 after the last rising edge of btn_raw.
  - A 3-cycle glitch (shorter than DB_CYCLES) -> no push, count stays 0.
- Order:
  - drain=0; press with sw=3, 5, 9 -> count=3.
  - Then drain=1 -> acc_en high on 3 consecutive cycles with acc_in=3, 5, 9, then empty=1.
  - Downstream accumulator ends at 4'h1 (17 mod 16).
- Overflow:
  - drain=0; 5 presses with sw=1..5 -> full after the 4th press; drop pulses once on the 5th.
  - Drain yields 1, 2, 3, 4 only.
- Simultaneous:
  - With full and drain=1, a press on the cycle a pop occurs -> no drop; count stays 4.
  - The pushed value emerges last.
- Empty push with drain=1 -> acc_en asserted exactly 1 cycle after the write edge, with acc_in = the pressed value.
